// File: rtl/mma_ctrl_pkg.sv
// mma_ctrl_pkg: shared state encoding and count-width helper for the MMA tile sequencer
package mma_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} mma_state_t;

    function automatic int kt_width(input int max_kt);
        return $clog2(max_kt + 1);
    endfunction

endpackage

// File: rtl/matrix_multiplication_accumulation.sv
// matrix_multiplication_accumulation: combinational signed D = A*B + C, sums wrap at 4P bits
module matrix_multiplication_accumulation #(
    parameter int M = 2,
    parameter int N = 2,
    parameter int K = 2,
    parameter int P = 8
) (
    input  logic [M-1:0][K-1:0][P-1:0]   a,
    input  logic [K-1:0][N-1:0][P-1:0]   b,
    input  logic [M-1:0][N-1:0][4*P-1:0] c,
    output logic [M-1:0][N-1:0][4*P-1:0] d
);

    // Low 4P bits of the product of sign-extended operands equal the signed product mod 2^4P
    function automatic logic [4*P-1:0] sext(input logic [P-1:0] x);
        return {{(3*P){x[P-1]}}, x};
    endfunction

    always_comb begin
        d = c;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < K; k++)
                    d[i][j] = d[i][j] + sext(a[i][k]) * sext(b[k][j]);
    end

endmodule

// File: rtl/mma_tile_sequencer.sv
// mma_tile_sequencer: streams A/B tile pairs through the MAC datapath, returns the accumulated result
module mma_tile_sequencer
    import mma_ctrl_pkg::*;
#(
    parameter int M      = 2,
    parameter int N      = 2,
    parameter int K      = 2,
    parameter int P      = 8,
    parameter int MAX_KT = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [kt_width(MAX_KT)-1:0]         num_k_tiles,
    input  logic [M-1:0][N-1:0][4*P-1:0]        c_init,
    output logic                                busy,
    input  logic                                a_valid,
    output logic                                a_ready,
    input  logic [M-1:0][K-1:0][P-1:0]          a_tile,
    input  logic                                b_valid,
    output logic                                b_ready,
    input  logic [K-1:0][N-1:0][P-1:0]          b_tile,
    output logic                                d_valid,
    input  logic                                d_ready,
    output logic [M-1:0][N-1:0][4*P-1:0]        d_out,
    output logic                                done
);

    localparam int KW = kt_width(MAX_KT);

    mma_state_t state, next_state;
    logic [KW-1:0] cnt;
    logic [M-1:0][N-1:0][4*P-1:0] acc, mac_d;
    logic accept, consume;

    matrix_multiplication_accumulation #(.M(M), .N(N), .K(K), .P(P)) u_mac (
        .a(a_tile),
        .b(b_tile),
        .c(acc),
        .d(mac_d)
    );

    // A and B move as a pair: neither side is acknowledged unless both are offered
    assign accept  = state == IDLE && start;
    assign consume = state == ACCUM && a_valid && b_valid;
    assign busy    = state != IDLE;
    assign a_ready = consume;
    assign b_ready = consume;
    assign d_valid = state == OUTPUT;
    assign d_out   = acc;
    assign done    = d_valid && d_ready;

    always_comb begin
        next_state = state;
        if (accept)
            next_state = num_k_tiles != '0 ? ACCUM : OUTPUT;
        else if (consume && cnt == KW'(1))
            next_state = OUTPUT;
        else if (done)
            next_state = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                acc <= c_init;
                cnt <= num_k_tiles;
            end else if (consume) begin
                acc <= mac_d;
                cnt <= cnt - KW'(1);
            end
        end
    end

endmodule

// File: doc/mma_tile_sequencer.md
# mma_tile_sequencer

Sequencing controller for the combinational signed matrix multiply-accumulate datapath (D = A·B + C, M×K by K×N, P-bit operands, 4P-bit accumulators). It accepts a job of `num_k_tiles` K-slices and streams A/B tile pairs through the datapath, one pair per cycle. It holds the running M×N sum in an internal accumulator register and returns the final result over a valid/ready output. It sits between the operand tile buffers and the result writeback in the GEMM tile engine.

## Interface
- `M`, default 2: rows of A, D.
- `N`, default 2: columns of B, D.
- `K`, default 2: inner dimension per tile.
- `P`, default 8: operand width. Accumulator width is 4P.
- `MAX_KT`, default 16: maximum K-tiles per job.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request. Accepted only in IDLE.
- `num_k_tiles`  in  $clog2(MAX_KT+1)  tile count, sampled with `start`. The value 0 is legal.
- `c_init`  in  signed [4P-1:0] [M][N]  initial accumulator, sampled with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `a_valid` / `a_ready`  in / out  1  A tile handshake.
- `a_tile`  in  signed [P-1:0] [M][K]  A tile.
- `b_valid` / `b_ready`  in / out  1  B tile handshake.
- `b_tile`  in  signed [P-1:0] [K][N]  B tile.
- `d_valid` / `d_ready`  out / in  1  result handshake.
- `d_out`  out  signed [4P-1:0] [M][N]  result. Registered; equals the accumulator.
- `done`  out  1  one-cycle pulse in the cycle the result is accepted.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT.
- **IDLE**
  - On `start`: acc ← `c_init` and cnt ← `num_k_tiles`.
  - Next state is ACCUM if `num_k_tiles` ≠ 0, otherwise OUTPUT.
- **ACCUM**
  - `a_ready` = `b_ready` = `a_valid && b_valid`. A and B are always consumed together, never one without the other.
  - On consume: acc ← datapath D (A·B + acc) and cnt ← cnt−1.
  - When the consume happens at cnt = 1, next state is OUTPUT.
  - Cycles without a consume leave acc and cnt unchanged.
- **OUTPUT**
  - `d_valid` = 1 and `d_out` = acc, held stable until `d_ready`.
  - On `d_valid && d_ready`: `done` pulses and the next state is IDLE.
- `start` outside IDLE is ignored, with no effect on state or data.
- Arithmetic:
  - Products are signed P×P, sign-extended to 4P.
  - Sums wrap modulo 2^(4P). There is no saturation and no overflow flag.
- `num_k_tiles` > `MAX_KT` cannot be represented beyond the port width. The block processes whatever count is presented.

## Timing
- Reset values: state IDLE, acc 0, cnt 0. `busy`, `a_ready`, `b_ready`, `d_valid` and `done` are 0; `d_out` is 0.
- Reset is asynchronous; its effect is immediate. A reset in any state, including mid-ACCUM, abandons the job. No partial result is emitted.
- `start` accepted at edge 0 gives ACCUM from cycle 1.
  - With both streams continuously valid, tiles are consumed in cycles 1..T.
  - `d_valid` rises in cycle T+1.
  - For T=0, `d_valid` rises in cycle 1.
- Throughput is one tile pair per cycle.
- Result to next job:
  - `d_ready` high in the first OUTPUT cycle puts the block in IDLE the following cycle.
  - A new `start` is accepted in that IDLE cycle, giving a minimum of one idle cycle between jobs.
- `a_ready`/`b_ready` depend combinationally on `a_valid`/`b_valid`. Upstream valid must not depend on ready.

## Structure
- Package `mma_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} mma_state_t`.
  - Function `kt_width(MAX_KT)` returning the count width.
- One sub-module instance: `matrix_multiplication_accumulation` (M, N, K, P). Its inputs are A = `a_tile`, B = `b_tile`, C = acc; its D output feeds the acc register.
- Everything else (FSM, counter, accumulator register, handshake logic) stays in this module.

## Test plan
- **Single tile:** M=N=K=2, P=8, T=1, C=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Required: `d_out`=[[19,22],[43,50]] with `d_valid` in cycle 2.
- **Two tiles:** T=2, the same A/B twice, C all 10. Required: `d_out`=[[48,54],[96,110]]. `a_ready` high in exactly 2 cycles.
- **Zero tiles:** T=0, C=[[1,2],[3,4]]. Required: `d_out`=C in cycle 1, and `a_ready`/`b_ready` never high.
- **Backpressure:** T=3 with `b_valid` low on alternate cycles. Required: consumes occur only when both valid are high. With `d_ready` held low for 3 cycles, `d_out` stays stable. `done` pulses on the accept cycle. A `start` pulse while busy is ignored.
- **Sign and wrap:**
  - A=B all −128, C=0, T=1: required `d_out` all 32768.
  - A=B all 1, C all 0x7FFFFFFF, T=1: required `d_out` all 0x80000001.
- **Reset mid-job:** assert `rst` after 1 of 3 tiles. Required: all outputs 0 and state IDLE. A following T=1 job matches the single-tile result.
